fb_scanout: RTL and testbench
=============================

FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 Parameters: FB_WIDTH, 160, framebuffer columns; FB_HEIGHT, 120, framebuffer rows; DATA_WIDTH, 12, pixel width; SCALE, 4, power-of-2 upscale factor; READ_LATENCY, 1, framebuffer read latency in cycles.
REQ-002 Parameters: H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48; V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33; SYNC_POL, 0, active sync level.
REQ-003 Port: clk_pix  in  1  pixel clock; single clock domain, also drives the framebuffer clk_read.
REQ-004 Port: rst  in  1  reset; synchronous, active-high.
REQ-005 Ports: addr_read  out  ADDR_WIDTH=$clog2(FB_WIDTH*FB_HEIGHT)  framebuffer read address; data_in  in  DATA_WIDTH  framebuffer read data.
REQ-006 Ports: border_color  in  DATA_WIDTH  fill outside the image; swap_req  in  1  request to swap front buffer; swap_ack  out  1  one-cycle swap done; fb_sel  out  1  current front buffer index.
REQ-007 Ports: hsync, vsync, de  out  1 each; pixel_out  out  DATA_WIDTH; frame_start  out  1  one-cycle pulse.

Function
REQ-008 Counters sx 0..H_TOTAL-1 and sy 0..V_TOTAL-1; sx wraps to 0 and increments sy; sy wraps to 0 after V_TOTAL-1.
REQ-009 Active: sx<H_ACTIVE and sy<V_ACTIVE; hsync = SYNC_POL for sx in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else !SYNC_POL; vsync uses the same rule on sy.
REQ-010 In-image: sx<FB_WIDTH*SCALE and sy<FB_HEIGHT*SCALE; addr_read = (sy/SCALE)*FB_WIDTH + sx/SCALE, driven combinationally from the counters.
REQ-011 Address arithmetic is incremental with no multiplier: row_base += FB_WIDTH on the last line of each SCALE-line group, row_base=0 at sy wrap; column index increments every SCALE pixels.
REQ-012 When not in-image, addr_read holds its last value; the value is don't-care for the check.
REQ-013 Active, hsync, vsync and in-image are delayed READ_LATENCY cycles, then registered together with the pixel mux; outputs lag the counters by READ_LATENCY+1 cycles.
REQ-014 pixel_out = data_in if delayed in-image, border_color if delayed active and not in-image, 0 when de=0.
REQ-015 frame_start pulses one cycle, one cycle after the counters reach (0,0); it is not delayed by READ_LATENCY.
REQ-016 swap_req sampled high sets swap_pending; it may be a pulse or a level, and multiple requests before service collapse into one.
REQ-017 Swap event: cycle where sx=0 and sy=V_ACTIVE (first blanking line) with pending, or swap_req high in that same cycle.
- fb_sel toggles on the next edge.
- swap_ack pulses one cycle, coincident with the new fb_sel.
- pending clears.
REQ-018 swap_req arriving after the swap event in the same frame is held pending until the next frame's event; fb_sel never changes during active lines.

Reset
REQ-019 While rst is high, at each clock edge: sx=0, sy=0, row_base=0, fb_sel=0, swap_pending=0, swap_ack=0, frame_start=0, de=0, pixel_out=0, hsync=vsync=!SYNC_POL; delay pipeline cleared to inactive.
REQ-020 Reset mid-frame discards any pending swap; the first cycle after rst falls begins at counter (0,0).

Structure
REQ-021 Package fb_pkg holds timing constants, H_TOTAL/V_TOTAL derivation, SYNC_POL default and the pixel type width; fb_scanout imports it.
REQ-022 One sub-module, vga_timing, owns sx/sy counters and raw sync/active generation; fb_scanout owns addressing, the delay line, the output mux and swap control.

Verification
REQ-023 Reset then run 2 frames: hsync period 800 with low width 96; vsync period 525 lines with low width 2 lines; de high for 640x480 per frame.
REQ-024 Framebuffer model with data = address, SCALE=4: pixel_out at screen (5,9) = 2*160+1 = 321, appearing READ_LATENCY+1 cycles after counter (5,9); each value repeats 4 pixels across and 4 lines down.
REQ-025 FB_WIDTH=100, SCALE=4, border_color=12'hF00: screen x in 400..639 outputs 12'hF00 with de=1; x in 0..399 outputs model data.
REQ-026 swap_req pulse at sy=100: fb_sel 0->1 and swap_ack high exactly at the edge after (sx=0, sy=480); no change before. Second pulse at sy=481: fb_sel toggles only in the next frame.
REQ-027 swap_req coincident with (0,480) is serviced that frame; rst asserted at sy=200 with pending swap: fb_sel stays 0, and outputs hold reset values until rst falls.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared timing defaults, total-period helper and control types for scanout.
// Latency: not applicable; holds declarations only.
// Backpressure: none; everything here runs on a free-running pixel clock.
package fb_pkg;

  // 640x480@60 timing, in pixels (horizontal) and lines (vertical)
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Sync pulses are active-low by default
  localparam logic SYNC_POL_DEF = 1'b0;

  // Framebuffer geometry and pixel format
  localparam int FB_WIDTH_DEF  = 160;
  localparam int FB_HEIGHT_DEF = 120;
  localparam int SCALE_DEF     = 4;
  localparam int PIX_W         = 12;

  // Full period of one axis: visible + front porch + sync + back porch
  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_DEF = timing_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = timing_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  // Per-pixel control travelling alongside the framebuffer read
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic in_img;
  } vid_ctl_t;

endpackage

// File: rtl/vga_timing.sv
// vga_timing: raster position counters plus raw sync / active-video generation.
// Latency: outputs are combinational from the sx/sy registers (zero cycles).
// Backpressure: none; counters advance every clk_pix cycle unless rst is high.
//
// Ports:
//   clk_pix, rst          pixel clock, synchronous active-high reset
//   sx, sy                current raster column / line
//   line_end, frame_end   last pixel of a line / last pixel of the frame
//   active, hsync, vsync  raw (undelayed) video timing for the current position
module vga_timing
  import fb_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = SYNC_POL_DEF,
  localparam int  SX_W     = $clog2(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  localparam int  SY_W     = $clog2(timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic            clk_pix,
  input  logic            rst,
  output logic [SX_W-1:0] sx,
  output logic [SY_W-1:0] sy,
  output logic            line_end,
  output logic            frame_end,
  output logic            active,
  output logic            hsync,
  output logic            vsync
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [SX_W-1:0] SX_LAST  = SX_W'(H_TOTAL - 1);
  localparam logic [SX_W-1:0] SX_ACT   = SX_W'(H_ACTIVE);
  localparam logic [SX_W-1:0] HS_START = SX_W'(H_ACTIVE + H_FP);
  localparam logic [SX_W-1:0] HS_END   = SX_W'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [SY_W-1:0] SY_LAST  = SY_W'(V_TOTAL - 1);
  localparam logic [SY_W-1:0] SY_ACT   = SY_W'(V_ACTIVE);
  localparam logic [SY_W-1:0] VS_START = SY_W'(V_ACTIVE + V_FP);
  localparam logic [SY_W-1:0] VS_END   = SY_W'(V_ACTIVE + V_FP + V_SYNC);

  assign line_end  = (sx == SX_LAST);
  assign frame_end = line_end && (sy == SY_LAST);

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sx <= '0;
      sy <= '0;
    end else if (line_end) begin
      sx <= '0;
      sy <= frame_end ? '0 : sy + 1'b1;
    end else begin
      sx <= sx + 1'b1;
    end
  end

  assign active = (sx < SX_ACT) && (sy < SY_ACT);
  assign hsync  = ((sx >= HS_START) && (sx < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vsync  = ((sy >= VS_START) && (sy < VS_END)) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: scans an upscaled framebuffer onto a VGA raster with border fill and double-buffer swap.
// Latency: video outputs lag the raster counters by READ_LATENCY+1 cycles; frame_start lags by 1.
// Backpressure: none; the framebuffer must return data exactly READ_LATENCY cycles after addr_read.
//
// Ports:
//   clk_pix, rst              pixel clock (also the framebuffer read clock), sync active-high reset
//   addr_read / data_in       framebuffer read address out, read data back
//   border_color              fill for active pixels outside the scaled image
//   swap_req/swap_ack/fb_sel  front-buffer swap request, one-cycle done pulse, current front buffer
//   hsync, vsync, de          aligned video timing
//   pixel_out, frame_start    pixel value (0 when de=0), one-cycle start-of-frame pulse
module fb_scanout
  import fb_pkg::*;
#(
  parameter int   FB_WIDTH     = FB_WIDTH_DEF,
  parameter int   FB_HEIGHT    = FB_HEIGHT_DEF,
  parameter int   DATA_WIDTH   = PIX_W,
  parameter int   SCALE        = SCALE_DEF,
  parameter int   READ_LATENCY = 1,
  parameter int   H_ACTIVE     = H_ACTIVE_DEF,
  parameter int   H_FP         = H_FP_DEF,
  parameter int   H_SYNC       = H_SYNC_DEF,
  parameter int   H_BP         = H_BP_DEF,
  parameter int   V_ACTIVE     = V_ACTIVE_DEF,
  parameter int   V_FP         = V_FP_DEF,
  parameter int   V_SYNC       = V_SYNC_DEF,
  parameter int   V_BP         = V_BP_DEF,
  parameter logic SYNC_POL     = SYNC_POL_DEF,
  localparam int  ADDR_WIDTH   = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic                  clk_pix,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] addr_read,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] border_color,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  fb_sel,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  frame_start
);

  localparam int SX_W       = $clog2(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int SY_W       = $clog2(timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int SCALE_LOG2 = $clog2(SCALE);

  localparam logic [SX_W-1:0]       IMG_W      = SX_W'(FB_WIDTH * SCALE);
  localparam logic [SY_W-1:0]       IMG_H      = SY_W'(FB_HEIGHT * SCALE);
  localparam logic [SY_W-1:0]       IMG_H_LAST = SY_W'(FB_HEIGHT * SCALE - 1);
  localparam logic [SY_W-1:0]       GROUP_MASK = SY_W'(SCALE - 1);
  localparam logic [SY_W-1:0]       SWAP_LINE  = SY_W'(V_ACTIVE);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP   = ADDR_WIDTH'(FB_WIDTH);

  localparam vid_ctl_t CTL_IDLE = '{active: 1'b0, hsync: ~SYNC_POL, vsync: ~SYNC_POL, in_img: 1'b0};

  logic [SX_W-1:0] sx;
  logic [SY_W-1:0] sy;
  logic            line_end;
  logic            frame_end;
  logic            raw_active;
  logic            raw_hsync;
  logic            raw_vsync;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk_pix   (clk_pix),
    .rst       (rst),
    .sx        (sx),
    .sy        (sy),
    .line_end  (line_end),
    .frame_end (frame_end),
    .active    (raw_active),
    .hsync     (raw_hsync),
    .vsync     (raw_vsync)
  );

  // ---------------------------------------------------------------------------
  // Framebuffer addressing
  // ---------------------------------------------------------------------------
  logic                  in_img;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] col_idx;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic                  group_last_line;

  assign in_img = (sx < IMG_W) && (sy < IMG_H);

  // SCALE is a power of two, so the column index is sx with the low bits
  // dropped; it steps by one every SCALE pixels.
  assign col_idx = ADDR_WIDTH'(sx >> SCALE_LOG2);

  assign group_last_line = ((sy & GROUP_MASK) == GROUP_MASK);

  // row_base tracks (sy/SCALE)*FB_WIDTH. It stops advancing on the last image
  // line so it never walks past the framebuffer during vertical blanking.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      row_base <= '0;
    end else if (frame_end) begin
      row_base <= '0;
    end else if (line_end && group_last_line && (sy < IMG_H_LAST)) begin
      row_base <= row_base + ROW_STEP;
    end
  end

  // Outside the image the address is parked at its last in-image value.
  assign addr_read = in_img ? (row_base + col_idx) : addr_hold;

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      addr_hold <= '0;
    end else begin
      addr_hold <= addr_read;
    end
  end

  // ---------------------------------------------------------------------------
  // Control delay line: keeps timing aligned with data_in
  // ---------------------------------------------------------------------------
  vid_ctl_t ctl_now;
  vid_ctl_t ctl_dly [READ_LATENCY];
  vid_ctl_t ctl_tap;

  assign ctl_now.active = raw_active;
  assign ctl_now.hsync  = raw_hsync;
  assign ctl_now.vsync  = raw_vsync;
  assign ctl_now.in_img = in_img;

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        ctl_dly[i] <= CTL_IDLE;
      end
    end else begin
      ctl_dly[0] <= ctl_now;
      for (int i = 1; i < READ_LATENCY; i++) begin
        ctl_dly[i] <= ctl_dly[i-1];
      end
    end
  end

  assign ctl_tap = ctl_dly[READ_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Output register and pixel mux
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      de        <= 1'b0;
      hsync     <= ~SYNC_POL;
      vsync     <= ~SYNC_POL;
      pixel_out <= '0;
    end else begin
      de    <= ctl_tap.active;
      hsync <= ctl_tap.hsync;
      vsync <= ctl_tap.vsync;
      if (!ctl_tap.active) begin
        pixel_out <= '0;
      end else if (ctl_tap.in_img) begin
        pixel_out <= data_in;
      end else begin
        pixel_out <= border_color;
      end
    end
  end

  // frame_start follows the counters directly, not the read pipeline.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= (sx == '0) && (sy == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Front-buffer swap: only ever serviced at the start of the first blanking
  // line, so fb_sel is stable for the whole visible part of every frame.
  // ---------------------------------------------------------------------------
  logic swap_pending;
  logic swap_evt;

  assign swap_evt = (sx == '0) && (sy == SWAP_LINE) && (swap_pending || swap_req);

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      fb_sel       <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
    end else begin
      swap_ack <= swap_evt;
      if (swap_evt) begin
        fb_sel       <= ~fb_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
`timescale 1ns/1ps
module tb_fb_scanout;

  // Reduced raster so several frames fit in a short run
  localparam int FBW = 8, FBH = 6, DW = 12, SC = 4, RL = 1;
  localparam int HA = 40, HFP = 4, HS = 6, HBP = 6;
  localparam int VA = 30, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;   // 56
  localparam int VT = VA + VFP + VS + VBP;   // 37
  localparam int FRAME = HT * VT;
  localparam int AW = $clog2(FBW * FBH);
  localparam int LAT = RL + 1;

  logic          clk_pix;
  logic          rst;
  logic [AW-1:0] addr_read;
  logic [DW-1:0] data_in;
  logic [DW-1:0] border_color;
  logic          swap_req;
  logic          swap_ack, fb_sel, hsync, vsync, de, frame_start;
  logic [DW-1:0] pixel_out;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int vectors = 0;
  int miscompares = 0;

  fb_scanout #(
    .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .DATA_WIDTH(DW), .SCALE(SC), .READ_LATENCY(RL),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0)
  ) dut (
    .clk_pix      (clk_pix),
    .rst          (rst),
    .addr_read    (addr_read),
    .data_in      (data_in),
    .border_color (border_color),
    .swap_req     (swap_req),
    .swap_ack     (swap_ack),
    .fb_sel       (fb_sel),
    .hsync        (hsync),
    .vsync        (vsync),
    .de           (de),
    .pixel_out    (pixel_out),
    .frame_start  (frame_start)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  // Framebuffer: one-cycle synchronous read
  always @(posedge clk_pix) data_in <= mem[addr_read];

  // ---------------------------------------------------------------------------
  // Reference model state: 'since' is the number of edges since the last
  // reset edge, i.e. the linear raster index of the current cycle.
  // ---------------------------------------------------------------------------
  int since = 0;
  bit model_on = 0;
  bit m_pend = 0, m_sel = 0, m_ack = 0;
  bit pin_phase = 0, rst_phase = 0;
  int hs_fall, vs_fall, de_cnt;
  logic hs_prev, vs_prev;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at index %0d: got %0h, expected %0h", name, since, got, exp);
    end
  endtask

  always @(negedge clk_pix) begin : chk
    int pos, px, py, opos, ox, oy;
    bit e_de, e_hs, e_vs, e_fs, evt;
    logic [DW-1:0] e_pix;
    if (model_on) begin
      pos = since % FRAME;
      px  = pos % HT;
      py  = pos / HT;
      if (since < LAT) begin
        e_de = 0; e_hs = 1; e_vs = 1; e_pix = '0;
      end else begin
        opos = (since - LAT) % FRAME;
        ox = opos % HT;
        oy = opos / HT;
        e_de = (ox < HA) && (oy < VA);
        e_hs = !((ox >= HA + HFP) && (ox < HA + HFP + HS));
        e_vs = !((oy >= VA + VFP) && (oy < VA + VFP + VS));
        if (!e_de) e_pix = '0;
        else if ((ox < FBW * SC) && (oy < FBH * SC)) e_pix = mem[(oy / SC) * FBW + ox / SC];
        else e_pix = border_color;
      end
      e_fs = (since >= 1) && (((since - 1) % FRAME) == 0);

      check("de", de, e_de);
      check("hsync", hsync, e_hs);
      check("vsync", vsync, e_vs);
      check("pixel_out", pixel_out, e_pix);
      check("frame_start", frame_start, e_fs);
      check("fb_sel", fb_sel, m_sel);
      check("swap_ack", swap_ack, m_ack);
      if ((px < FBW * SC) && (py < FBH * SC))
        check("addr_read", addr_read, (py / SC) * FBW + px / SC);

      // Acks may only ever land on the edge after the first blanking line start
      if (swap_ack === 1'b1) check("ack_position", (since - 1) % FRAME, VA * HT);

      // Hand-computed points for the data=address image and the swap sequence
      if (pin_phase) begin
        if (since == 1)                check("pin_frame_start", frame_start, 1);
        if (since == 9*HT + 5 + LAT)   check("pin_px_5_9", pixel_out, 17);
        if (since == 9*HT + 7 + LAT)   check("pin_px_7_9", pixel_out, 17);
        if (since == 9*HT + 8 + LAT)   check("pin_px_8_9", pixel_out, 18);
        if (since == 11*HT + 5 + LAT)  check("pin_px_5_11", pixel_out, 17);
        if (since == 12*HT + 5 + LAT)  check("pin_px_5_12", pixel_out, 25);
        if (since == 23*HT + 31 + LAT) check("pin_px_31_23", pixel_out, 47);
        if (since == 3*HT + 36 + LAT)  check("pin_border", pixel_out, 12'hF00);
        if (since == 3*HT + 36 + LAT)  check("pin_border_de", de, 1);
        if (since == 3*HT + 45 + LAT)  check("pin_hsync_low", hsync, 0);
        if (since == 3*HT + 45 + LAT)  check("pin_blank_px", pixel_out, 0);
        if (since == VA*HT)            check("pin_sel_before", fb_sel, 0);
        if (since == VA*HT + 1)        check("pin_sel_after", fb_sel, 1);
        if (since == VA*HT + 1)        check("pin_ack", swap_ack, 1);
        if (since == FRAME + VA*HT)    check("pin_sel_f1_before", fb_sel, 1);
        if (since == FRAME + VA*HT + 1) check("pin_sel_f1_after", fb_sel, 0);
        if (since == 2*FRAME + VA*HT + 1) check("pin_sel_coincident", fb_sel, 1);
      end
      if (rst_phase && since == VA*HT + 1) begin
        check("pin_rst_sel", fb_sel, 0);
        check("pin_rst_no_ack", swap_ack, 0);
      end

      // Sync period / width and active-pixel count per frame
      if (since == 0) begin
        hs_fall = -1; vs_fall = -1; de_cnt = 0; hs_prev = 1; vs_prev = 1;
      end
      if (hs_prev === 1'b1 && hsync === 1'b0) begin
        if (hs_fall >= 0) check("hsync_period", since - hs_fall, HT);
        hs_fall = since;
      end
      if (hs_prev === 1'b0 && hsync === 1'b1 && hs_fall >= 0) check("hsync_width", since - hs_fall, HS);
      if (vs_prev === 1'b1 && vsync === 1'b0) begin
        if (vs_fall >= 0) check("vsync_period", since - vs_fall, FRAME);
        vs_fall = since;
      end
      if (vs_prev === 1'b0 && vsync === 1'b1 && vs_fall >= 0) check("vsync_width", since - vs_fall, VS * HT);
      hs_prev = hsync;
      vs_prev = vsync;
      if (since <= 1) de_cnt = 0;
      else if (de === 1'b1) de_cnt++;
      if (frame_start === 1'b1 && since > 1) begin
        check("de_count", de_cnt, HA * VA);
        de_cnt = 0;
      end
    end

    // Advance the model to the next cycle
    if (rst === 1'b1) begin
      model_on = 1; since = 0; m_pend = 0; m_sel = 0; m_ack = 0;
    end else if (model_on) begin
      evt = (px == 0) && (py == VA) && (m_pend || swap_req);
      m_ack = evt;
      if (evt) begin
        m_sel = !m_sel;
        m_pend = 0;
      end else if (swap_req) begin
        m_pend = 1;
      end
      since++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  // Returns just after the edge that starts the cycle at raster position (x,y)
  task automatic wait_pos(input int x, input int y);
    int n;
    n = 0;
    @(negedge clk_pix); #1;
    while (((since % FRAME) != y * HT + x) && n < 3 * FRAME) begin
      @(negedge clk_pix); #1;
      n++;
    end
    if (n >= 3 * FRAME) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_pos(%0d,%0d) timeout: got no match, expected position within %0d cycles", x, y, 3 * FRAME);
    end
    @(posedge clk_pix); #1;
  endtask

  task automatic pulse_req();
    swap_req = 1;
    tick();
    swap_req = 0;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int burst, mid;
    rst = 1;
    swap_req = 0;
    border_color = 12'hF00;
    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a);
    repeat (3) @(posedge clk_pix);
    #1;
    rst = 0;
    pin_phase = 1;

    // Swap sequence: early pulse, late pulse, then a coincident request
    wait_pos(0, 10);  pulse_req();
    wait_pos(0, 31);  pulse_req();
    wait_pos(0, VA);
    wait_pos(0, VA);  pulse_req();
    wait_pos(0, 2);
    pin_phase = 0;

    // Mid-frame reset with a swap pending
    wait_pos(0, 5);   pulse_req();
    wait_pos(0, 20);
    rst = 1;
    repeat (3) tick();
    rst = 0;
    rst_phase = 1;
    wait_pos(0, 32);
    rst_phase = 0;

    // Randomised framebuffer, border and swap traffic
    burst = 0;
    for (int r = 0; r < 8; r++) begin
      rst = 1;
      swap_req = 0;
      tick(); tick();
      border_color = DW'($urandom);
      for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);
      tick();
      rst = 0;
      mid = $urandom_range(100, FRAME);
      for (int c = 0; c < FRAME + 600; c++) begin
        if (burst > 0) begin
          swap_req = 1;
          burst--;
        end else begin
          swap_req = 0;
          if ($urandom_range(0, 299) == 0) burst = $urandom_range(1, 4);
        end
        if (r % 3 == 2 && c == mid) rst = 1;
        if (r % 3 == 2 && c == mid + 2) rst = 0;
        tick();
      end
      swap_req = 0;
      burst = 0;
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
